serial_frame_deframer: RTL and testbench
========================================

Name: serial_frame_deframer

Overview:
Downstream consumer of the single-bit SISO shift-register stream. It samples one serial bit per enabled clock and hunts for a sync word. After lock it deserializes a fixed number of payload words, MSB first, and hands each word to parallel logic over a valid/ready handshake. It then returns to hunting for the next sync word.

Parameters:
WIDTH, 8, payload word width in bits (>=2)
SYNC_LEN, 8, sync word length in bits (>=2, <=32)
SYNC, 8'hA5, sync pattern, compared MSB-first (first received bit = SYNC[SYNC_LEN-1])
FRAME_WORDS, 2, payload words per frame (>=1)

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in  input  1  serial data bit (SISO output)
in_en  input  1  bit strobe: in is sampled only on edges where in_en=1
data_out  output  WIDTH  deserialized payload word
data_valid  output  1  data_out holds an unconsumed word
data_ready  input  1  consumer accepts data_out when data_valid & data_ready
in_frame  output  1  high while in COLLECT state
sync_det  output  1  one-cycle pulse: sync word matched
frame_done  output  1  one-cycle pulse: last payload word of frame completed
overrun  output  1  one-cycle pulse: completed word dropped due to backpressure

Behaviour:
- Reset (async assert, sync release on clk): state=HUNT; window, bit counter, word index=0. Output values: data_out=0, data_valid=0, in_frame=0, sync_det=0, frame_done=0, overrun=0.
- Only edges with in_en=1 advance the window or counters. in_en=0 edges hold all shift/count state; handshake logic still runs.
- HUNT:
  - Shift register window <= {window[SYNC_LEN-2:0], in}.
  - Fill counter saturates at SYNC_LEN.
  - Match is taken only when the fill counter shows >= SYNC_LEN bits received since entering HUNT, including the current bit. This prevents a cleared window from matching SYNC=0.
  - On match: next state COLLECT; sync_det=1 for the following cycle; bit count=0; word index=0.
- COLLECT:
  - Shift word register, MSB first.
  - At the edge sampling bit WIDTH-1, the word is complete, and:
    - if data_valid=0, or data_ready=1 in the same cycle: data_out <= word and data_valid <= 1, visible in the next cycle (latency: 1 clk after the last bit edge);
    - else: the word is dropped, data_out is unchanged, and overrun=1 for one cycle.
  - Word index increments on every completed word, dropped words included.
  - On completion of word FRAME_WORDS-1: frame_done=1 next cycle; state to HUNT; window and fill counter cleared. Sync detection is not overlapped with payload.
- Handshake:
  - data_valid clears on data_ready=1 unless a new word loads in the same cycle, in which case it stays 1 with the new data.
  - data_out is stable while data_valid=1 and data_ready=0.
  - data_ready is ignored when data_valid=0.
- in_frame=1 exactly while state=COLLECT (registered, same cycle as state).
- All pulse outputs are registered and last exactly one cycle.
- Reset mid-frame discards the partial word and any pending data_valid immediately.

Test Plan:
- Lock and deliver, data_ready=1, in_en=1, defaults:
  - Stimulus: bits of 0xA5, 0x3C, 0xC3, MSB first.
  - Required: sync_det pulses the cycle after the 8th bit; in_frame=1 for 16 cycles; data_out=0x3C with data_valid for 1 cycle, 8 cycles later data_out=0xC3 with frame_done; then in_frame=0.
- False sync / idle:
  - Stimulus: constant in=1 for 400 ns (clk period 20 ns), then 0xA4 followed by 0x00.
  - Required: sync_det, in_frame and data_valid stay 0.
- Backpressure:
  - Stimulus: data_ready=0 through the full frame 0xA5, 0x11, 0x22.
  - Required: data_out=0x11 held with data_valid=1; overrun pulses at 0x22 completion; frame_done still pulses; after data_ready=1, data_valid drops next cycle.
- Simultaneous accept and load:
  - Stimulus: data_ready asserted exactly on the edge completing word 2 while word 1 is pending.
  - Required: data_out switches 0x11 to 0x22, data_valid stays 1, no overrun.
- Strobe gaps:
  - Stimulus: the first scenario's stream with in_en=0 inserted on every other clock.
  - Required: identical data_out sequence; each event is delayed to one cycle after its final enabled bit edge.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 during word 1 bit 4, release, then resend 0xA5, 0x3C, 0xC3.
  - Required: all outputs 0 immediately at assertion; after release, clean lock and delivery as in the first scenario.

Source files
------------

// File: rtl/serial_frame_deframer.sv
// Serial deframer: hunts for a sync word in a strobed bit stream, then deserializes
// FRAME_WORDS payload words (MSB first) and presents them over a valid/ready handshake.
module serial_frame_deframer #(
  parameter int unsigned          WIDTH       = 8,
  parameter int unsigned          SYNC_LEN    = 8,
  parameter logic [SYNC_LEN-1:0]  SYNC        = 8'hA5,
  parameter int unsigned          FRAME_WORDS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in,
  input  logic             i_in_en,
  output logic [WIDTH-1:0] o_data_out,
  output logic             o_data_valid,
  input  logic             i_data_ready,
  output logic             o_in_frame,
  output logic             o_sync_det,
  output logic             o_frame_done,
  output logic             o_overrun
);

  localparam int unsigned FillW = $clog2(SYNC_LEN + 1);
  localparam int unsigned BitW  = $clog2(WIDTH);
  localparam int unsigned IdxW  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  localparam logic [FillW-1:0] FillMax  = FillW'(SYNC_LEN);
  localparam logic [FillW-1:0] FillPrev = FillW'(SYNC_LEN - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(WIDTH - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(FRAME_WORDS - 1);

  typedef enum logic [0:0] {StHunt, StCollect} state_e;

  state_e              r_state;
  logic [SYNC_LEN-1:0] r_window;
  logic [FillW-1:0]    r_fill;
  logic [WIDTH-1:0]    r_word;
  logic [BitW-1:0]     r_bit_cnt;
  logic [IdxW-1:0]     r_word_idx;
  logic [WIDTH-1:0]    r_data_out;
  logic                r_data_valid;
  logic                r_in_frame;
  logic                r_sync_det;
  logic                r_frame_done;
  logic                r_overrun;

  logic [SYNC_LEN-1:0] w_window_nxt;
  logic [WIDTH-1:0]    w_word_nxt;
  logic                w_match;

  assign w_window_nxt = {r_window[SYNC_LEN-2:0], i_in};
  assign w_word_nxt   = {r_word[WIDTH-2:0], i_in};
  // Fill check keeps a cleared window from matching an all-zero sync pattern.
  assign w_match      = (r_fill >= FillPrev) && (w_window_nxt == SYNC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StHunt;
      r_window     <= '0;
      r_fill       <= '0;
      r_word       <= '0;
      r_bit_cnt    <= '0;
      r_word_idx   <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_in_frame   <= 1'b0;
      r_sync_det   <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_sync_det   <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      if (r_data_valid && i_data_ready) r_data_valid <= 1'b0;

      if (i_in_en) begin
        unique case (r_state)
          StHunt: begin
            r_window <= w_window_nxt;
            if (r_fill != FillMax) r_fill <= r_fill + FillW'(1);
            if (w_match) begin
              r_state    <= StCollect;
              r_in_frame <= 1'b1;
              r_sync_det <= 1'b1;
              r_bit_cnt  <= '0;
              r_word_idx <= '0;
            end
          end
          StCollect: begin
            r_word <= w_word_nxt;
            if (r_bit_cnt == BitLast) begin
              r_bit_cnt <= '0;
              // A word completing while the previous one is still held is dropped.
              if (!r_data_valid || i_data_ready) begin
                r_data_out   <= w_word_nxt;
                r_data_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
              if (r_word_idx == IdxLast) begin
                r_state      <= StHunt;
                r_in_frame   <= 1'b0;
                r_frame_done <= 1'b1;
                r_window     <= '0;
                r_fill       <= '0;
                r_word_idx   <= '0;
              end else begin
                r_word_idx <= r_word_idx + IdxW'(1);
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + BitW'(1);
            end
          end
          default: r_state <= StHunt;
        endcase
      end
    end
  end

  assign o_data_out   = r_data_out;
  assign o_data_valid = r_data_valid;
  assign o_in_frame   = r_in_frame;
  assign o_sync_det   = r_sync_det;
  assign o_frame_done = r_frame_done;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_serial_frame_deframer.sv
// Bench for serial_frame_deframer: directed frames plus random traffic, every cycle checked
// against a queue-based model of the framing rules.
module tb_serial_frame_deframer;

  localparam int unsigned WIDTH       = 8;
  localparam int unsigned SYNC_LEN    = 8;
  localparam int unsigned SYNC_VAL    = 32'hA5;
  localparam int unsigned FRAME_WORDS = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_in = 1'b0;
  logic             i_in_en = 1'b0;
  logic             i_data_ready = 1'b0;
  logic [WIDTH-1:0] o_data_out;
  logic             o_data_valid;
  logic             o_in_frame;
  logic             o_sync_det;
  logic             o_frame_done;
  logic             o_overrun;

  int n_vec = 0;
  int n_err = 0;

  serial_frame_deframer #(
    .WIDTH       (WIDTH),
    .SYNC_LEN    (SYNC_LEN),
    .SYNC        (8'hA5),
    .FRAME_WORDS (FRAME_WORDS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_in         (i_in),
    .i_in_en      (i_in_en),
    .o_data_out   (o_data_out),
    .o_data_valid (o_data_valid),
    .i_data_ready (i_data_ready),
    .o_in_frame   (o_in_frame),
    .o_sync_det   (o_sync_det),
    .o_frame_done (o_frame_done),
    .o_overrun    (o_overrun)
  );

  always #10 clk = ~clk;

  // Reference model: received bits kept as queues, words rebuilt arithmetically.
  bit      m_collect;
  bit      m_hunt_q[$];
  bit      m_pay_q[$];
  int      m_idx;
  int      m_data;
  bit      m_valid;
  bit      m_sync;
  bit      m_done;
  bit      m_ovr;

  function automatic int q_value(input bit q[$]);
    int v = 0;
    foreach (q[i]) v = v * 2 + int'(q[i]);
    return v;
  endfunction

  task automatic model_reset();
    m_collect = 0;
    m_hunt_q.delete();
    m_pay_q.delete();
    m_idx = 0; m_data = 0; m_valid = 0;
    m_sync = 0; m_done = 0; m_ovr = 0;
  endtask

  task automatic model_step(input bit b, input bit en, input bit rdy);
    bit nv;
    int w;
    nv = m_valid && !rdy;
    m_sync = 0; m_done = 0; m_ovr = 0;
    if (en) begin
      if (!m_collect) begin
        m_hunt_q.push_back(b);
        if (m_hunt_q.size() > SYNC_LEN) void'(m_hunt_q.pop_front());
        if (m_hunt_q.size() == SYNC_LEN && q_value(m_hunt_q) == int'(SYNC_VAL)) begin
          m_collect = 1; m_sync = 1; m_idx = 0;
          m_pay_q.delete();
        end
      end else begin
        m_pay_q.push_back(b);
        if (m_pay_q.size() == WIDTH) begin
          w = q_value(m_pay_q);
          m_pay_q.delete();
          if (!m_valid || rdy) begin
            m_data = w; nv = 1;
          end else begin
            m_ovr = 1;
          end
          m_idx++;
          if (m_idx == FRAME_WORDS) begin
            m_done = 1; m_collect = 0;
            m_hunt_q.delete();
          end
        end
      end
    end
    m_valid = nv;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("data_out",   32'(o_data_out),   32'(m_data));
    chk("data_valid", 32'(o_data_valid), 32'(m_valid));
    chk("in_frame",   32'(o_in_frame),   32'(m_collect));
    chk("sync_det",   32'(o_sync_det),   32'(m_sync));
    chk("frame_done", 32'(o_frame_done), 32'(m_done));
    chk("overrun",    32'(o_overrun),    32'(m_ovr));
  endtask

  task automatic step(input bit b, input bit en, input bit rdy);
    i_in = b; i_in_en = en; i_data_ready = rdy;
    model_step(b, en, rdy);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Sends one byte MSB first; rdy_last overrides ready on the final bit edge.
  task automatic send_byte(input logic [7:0] v, input bit gaps, input bit rdy,
                           input bit rdy_last);
    for (int i = 7; i >= 0; i--) begin
      if (gaps) step(1'($urandom), 1'b0, rdy);
      step(v[i], 1'b1, (i == 0) ? rdy_last : rdy);
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input bit gaps, input bit rdy);
    send_byte(a, gaps, rdy, rdy);
    send_byte(b, gaps, rdy, rdy);
    send_byte(c, gaps, rdy, rdy);
  endtask

  initial begin
    model_reset();
    #25;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Lock and deliver
    send_frame(8'hA5, 8'h3C, 8'hC3, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);

    // False sync / idle
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1);
    send_byte(8'hA4, 1'b0, 1'b1, 1'b1);
    send_byte(8'h00, 1'b0, 1'b1, 1'b1);

    // Backpressure through a whole frame, then release
    send_frame(8'hA5, 8'h11, 8'h22, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Accept and load on the same edge
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Strobe gaps
    send_frame(8'hA5, 8'h3C, 8'hC3, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Reset mid-frame during word 1 bit 4
    send_byte(8'hA5, 1'b0, 1'b1, 1'b1);
    for (int i = 7; i >= 4; i--) step(1'b1, 1'b1, 1'b1);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'hA5, 8'h3C, 8'hC3, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);

    // Random traffic: noise, embedded frames, random strobe and ready
    for (int f = 0; f < 40; f++) begin
      int noise = $urandom_range(0, 12);
      for (int i = 0; i < noise; i++) step(1'($urandom), 1'($urandom), 1'($urandom));
      for (int k = 0; k < 3; k++) begin
        logic [7:0] v;
        v = (k == 0) ? 8'hA5 : 8'($urandom);
        for (int i = 7; i >= 0; i--) begin
          while ($urandom_range(0, 3) == 0) step(1'($urandom), 1'b0, 1'($urandom));
          step(v[i], 1'b1, ($urandom_range(0, 2) != 0));
        end
      end
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
